a5_1_keystream_gen: RTL and testbench

A5/1 keystream generator: three majority-clocked LFSRs (19/22/23 bits) loaded from a 64-bit session key and a 22-bit frame number. It produces one keystream bit per enabled clock. It sits directly upstream of the bit-serial XOR stage: its `ks_bit` drives the keystream input of that stage, once per image bit. A full 256×256 8-bit image is 524288 bits.

---
 rtl/a5_1_keystream_gen.sv | 214 +++++++++++++++++++++
 tb/tb_a5_1_keystream_gen.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/a5_1_keystream_gen.sv
// A5/1 keystream generator: three majority-clocked LFSRs
// seeded from a 64-bit session key and a 22-bit frame number.
module a5_1_keystream_gen #(
  parameter int unsigned NUM_BITS   = 524288,
  parameter int unsigned MIX_CYCLES = 100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [63:0] key,
  input  logic [21:0] frame,
  input  logic        ks_en,
  output logic        ks_bit,
  output logic        ks_valid,
  output logic        busy,
  output logic        done
);

  localparam int unsigned MAX_A =
    (NUM_BITS > 64) ? NUM_BITS : 64;
  localparam int unsigned MAX_B =
    (MIX_CYCLES > MAX_A) ? MIX_CYCLES : MAX_A;
  localparam int unsigned CW = $clog2(MAX_B + 1);

  localparam logic [CW-1:0] KEY_LAST = CW'(63);
  localparam logic [CW-1:0] FRM_LAST = CW'(21);
  localparam logic [CW-1:0] MIX_LAST =
    CW'(MIX_CYCLES - 1);
  localparam logic [CW-1:0] RUN_END = CW'(NUM_BITS);

  typedef enum logic [2:0] {
    IDLE,
    LOAD_KEY,
    LOAD_FRAME,
    MIX,
    RUN,
    DONE
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [18:0]   r1_q, r1_d;
  logic [21:0]   r2_q, r2_d;
  logic [22:0]   r3_q, r3_d;
  logic [63:0]   key_q, key_d;
  logic [21:0]   frame_q, frame_d;
  logic          ks_bit_q, ks_bit_d;
  logic          ks_valid_q, ks_valid_d;

  logic          maj;
  logic          load_bit;
  logic [18:0]   r1_m;
  logic [21:0]   r2_m;
  logic [22:0]   r3_m;

  function automatic logic [18:0] r1_step(
    input logic [18:0] r,
    input logic        in
  );
    return {r[17:0],
            r[13] ^ r[16] ^ r[17] ^ r[18] ^ in};
  endfunction

  function automatic logic [21:0] r2_step(
    input logic [21:0] r,
    input logic        in
  );
    return {r[20:0], r[20] ^ r[21] ^ in};
  endfunction

  function automatic logic [22:0] r3_step(
    input logic [22:0] r,
    input logic        in
  );
    return {r[21:0],
            r[7] ^ r[20] ^ r[21] ^ r[22] ^ in};
  endfunction

  // Majority-clocked successor, shared by MIX and RUN
  always_comb begin
    maj = (r1_q[8] & r2_q[10]) |
          (r1_q[8] & r3_q[10]) |
          (r2_q[10] & r3_q[10]);
    r1_m = (r1_q[8] == maj) ?
      r1_step(r1_q, 1'b0) : r1_q;
    r2_m = (r2_q[10] == maj) ?
      r2_step(r2_q, 1'b0) : r2_q;
    r3_m = (r3_q[10] == maj) ?
      r3_step(r3_q, 1'b0) : r3_q;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    r1_d       = r1_q;
    r2_d       = r2_q;
    r3_d       = r3_q;
    key_d      = key_q;
    frame_d    = frame_q;
    ks_bit_d   = ks_bit_q;
    ks_valid_d = 1'b0;
    load_bit   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          key_d   = key;
          frame_d = frame;
          r1_d    = '0;
          r2_d    = '0;
          r3_d    = '0;
          cnt_d   = '0;
          state_d = LOAD_KEY;
        end
      end

      // Seed bits are consumed LSB-first from a shifting copy
      LOAD_KEY: begin
        load_bit = key_q[0];
        key_d    = key_q >> 1;
        r1_d     = r1_step(r1_q, load_bit);
        r2_d     = r2_step(r2_q, load_bit);
        r3_d     = r3_step(r3_q, load_bit);
        if (cnt_q == KEY_LAST) begin
          cnt_d   = '0;
          state_d = LOAD_FRAME;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      LOAD_FRAME: begin
        load_bit = frame_q[0];
        frame_d  = frame_q >> 1;
        r1_d     = r1_step(r1_q, load_bit);
        r2_d     = r2_step(r2_q, load_bit);
        r3_d     = r3_step(r3_q, load_bit);
        if (cnt_q == FRM_LAST) begin
          cnt_d   = '0;
          state_d = MIX;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      MIX: begin
        r1_d = r1_m;
        r2_d = r2_m;
        r3_d = r3_m;
        if (cnt_q == MIX_LAST) begin
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      // Leave one cycle after the last bit so done trails it
      RUN: begin
        if (cnt_q == RUN_END) begin
          cnt_d   = '0;
          state_d = DONE;
        end else if (ks_en) begin
          r1_d       = r1_m;
          r2_d       = r2_m;
          r3_d       = r3_m;
          ks_bit_d   = r1_m[18] ^ r2_m[21] ^ r3_m[22];
          ks_valid_d = 1'b1;
          cnt_d      = cnt_q + CW'(1);
        end
      end

      DONE: begin
        cnt_d   = '0;
        state_d = IDLE;
      end

      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      r1_q       <= '0;
      r2_q       <= '0;
      r3_q       <= '0;
      key_q      <= '0;
      frame_q    <= '0;
      ks_bit_q   <= 1'b0;
      ks_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      r1_q       <= r1_d;
      r2_q       <= r2_d;
      r3_q       <= r3_d;
      key_q      <= key_d;
      frame_q    <= frame_d;
      ks_bit_q   <= ks_bit_d;
      ks_valid_q <= ks_valid_d;
    end
  end

  assign ks_bit   = ks_bit_q;
  assign ks_valid = ks_valid_q;
  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);

endmodule

// File: tb/tb_a5_1_keystream_gen.sv
// Directed bench for a5_1_keystream_gen using the
// classic A5/1 known-answer vector.
module tb_a5_1_keystream_gen;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [63:0] key;
  logic [21:0] frame;
  logic        ks_en;
  logic        ks_bit;
  logic        ks_valid;
  logic        busy;
  logic        done;

  int nvec;
  int nerr;

  logic [63:0]  kat_key;
  logic [21:0]  kat_frm;
  logic [119:0] kat;

  a5_1_keystream_gen #(
    .NUM_BITS  (114),
    .MIX_CYCLES(100)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .key     (key),
    .frame   (frame),
    .ks_en   (ks_en),
    .ks_bit  (ks_bit),
    .ks_valid(ks_valid),
    .busy    (busy),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one start and records the response; obs k is cycle k
  task automatic run_capture(
    input  logic [63:0]  k,
    input  logic [21:0]  f,
    input  bit           stall,
    input  int           inj_cyc,
    input  int           abort_at,
    output int           nv,
    output int           fv_cyc,
    output int           dn_cyc,
    output int           end_cyc,
    output int           dn_cnt,
    output logic [119:0] bits,
    output int           unstable,
    output bit           tmo,
    output bit           busy1
  );
    logic prev;
    nv = 0; fv_cyc = -1; dn_cyc = -1;
    end_cyc = -1; dn_cnt = 0; bits = '0;
    unstable = 0; tmo = 1'b1; busy1 = 1'b0;
    @(negedge clk);
    key = k; frame = f;
    start = 1'b1; ks_en = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    key = ~k; frame = ~f;
    busy1 = busy;
    prev = ks_bit;
    for (int cyc = 1; cyc < 4000; cyc++) begin
      if (ks_valid) begin
        if (nv < 120) bits[119-nv] = ks_bit;
        if (fv_cyc < 0) fv_cyc = cyc;
        nv++;
      end else if (ks_bit !== prev) begin
        unstable++;
      end
      if (done) begin
        dn_cnt++;
        if (dn_cyc < 0) dn_cyc = cyc;
      end
      if ((dn_cyc >= 0 && !busy) ||
          (abort_at > 0 && nv == abort_at)) begin
        end_cyc = cyc;
        tmo = 1'b0;
        break;
      end
      prev = ks_bit;
      @(negedge clk);
      ks_en = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      start = (cyc == inj_cyc);
      @(posedge clk); #1;
    end
    start = 1'b0;
    ks_en = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0; start = 1'b1;
    key = kat_key; frame = kat_frm;
    repeat (3) @(posedge clk);
    #1;
    nvec++;
    if ({ks_bit, ks_valid, busy, done} !== 4'b0000) begin
      nerr++;
      $display("FAIL reset_outs got=%b want=0000",
               {ks_bit, ks_valid, busy, done});
    end
    @(negedge clk);
    start = 1'b0; rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    nvec++;
    if ({ks_valid, busy, done} !== 3'b000) begin
      nerr++;
      $display("FAIL reset_release got=%b want=000",
               {ks_valid, busy, done});
    end
  endtask

  task automatic test_known_answer();
    int nv, fv, dc, ec, dn, us;
    logic [119:0] b;
    bit tmo, b1;
    run_capture(kat_key, kat_frm, 1'b0, -1, -1,
                nv, fv, dc, ec, dn, b, us, tmo, b1);
    nvec++;
    if (tmo !== 1'b0) begin
      nerr++;
      $display("FAIL kat_timeout got=%0d want=0", tmo);
    end
    nvec++;
    if (b1 !== 1'b1) begin
      nerr++;
      $display("FAIL kat_busy_c1 got=%0d want=1", b1);
    end
    nvec++;
    if (fv != 188) begin
      nerr++;
      $display("FAIL kat_first_valid got=%0d want=188", fv);
    end
    nvec++;
    if (dc != 302) begin
      nerr++;
      $display("FAIL kat_done_cyc got=%0d want=302", dc);
    end
    nvec++;
    if (ec != 303 || dn != 1) begin
      nerr++;
      $display("FAIL kat_busy_fall got=%0d/%0d want=303/1",
               ec, dn);
    end
    nvec++;
    if (nv != 114) begin
      nerr++;
      $display("FAIL kat_count got=%0d want=114", nv);
    end
    nvec++;
    if (b[119:96] !== 24'h534EAA) begin
      nerr++;
      $display("FAIL kat_first24 got=%h want=534eaa",
               b[119:96]);
    end
    nvec++;
    if (b[119:6] !== kat[119:6]) begin
      nerr++;
      $display("FAIL kat_bits got=%h want=%h", b, kat);
    end
  endtask

  task automatic test_stall();
    int nv, fv, dc, ec, dn, us;
    logic [119:0] b;
    bit tmo, b1;
    run_capture(kat_key, kat_frm, 1'b1, -1, -1,
                nv, fv, dc, ec, dn, b, us, tmo, b1);
    nvec++;
    if (tmo !== 1'b0 || nv != 114) begin
      nerr++;
      $display("FAIL stall_count got=%0d tmo=%0d want=114",
               nv, tmo);
    end
    nvec++;
    if (b[119:6] !== kat[119:6]) begin
      nerr++;
      $display("FAIL stall_bits got=%h want=%h", b, kat);
    end
    nvec++;
    if (us != 0) begin
      nerr++;
      $display("FAIL stall_hold got=%0d want=0", us);
    end
    nvec++;
    if (dn != 1) begin
      nerr++;
      $display("FAIL stall_done got=%0d want=1", dn);
    end
  endtask

  task automatic test_start_while_busy();
    int nv, fv, dc, ec, dn, us;
    logic [119:0] b;
    bit tmo, b1;
    run_capture(kat_key, kat_frm, 1'b0, 50, -1,
                nv, fv, dc, ec, dn, b, us, tmo, b1);
    nvec++;
    if (tmo !== 1'b0 || nv != 114 ||
        b[119:6] !== kat[119:6]) begin
      nerr++;
      $display("FAIL busy_start got=%h n=%0d want=%h",
               b, nv, kat);
    end
    nvec++;
    if (fv != 188 || dc != 302) begin
      nerr++;
      $display("FAIL busy_start_tim got=%0d/%0d want=188/302",
               fv, dc);
    end
  endtask

  task automatic test_start_on_done();
    int nv, fv, dc, ec, dn, us;
    logic [119:0] b;
    bit tmo, b1;
    run_capture(kat_key, kat_frm, 1'b0, 302, -1,
                nv, fv, dc, ec, dn, b, us, tmo, b1);
    repeat (2) @(posedge clk);
    #1;
    nvec++;
    if (tmo !== 1'b0 || busy !== 1'b0) begin
      nerr++;
      $display("FAIL done_start got=%0d want=0", busy);
    end
  endtask

  task automatic test_reset_mid_run();
    int nv, fv, dc, ec, dn, us;
    logic [119:0] b;
    bit tmo, b1;
    run_capture(kat_key, kat_frm, 1'b0, -1, 40,
                nv, fv, dc, ec, dn, b, us, tmo, b1);
    nvec++;
    if (tmo !== 1'b0 || nv != 40 ||
        b[119:80] !== kat[119:80]) begin
      nerr++;
      $display("FAIL mid_prefix got=%h n=%0d want=%h",
               b[119:80], nv, kat[119:80]);
    end
    rst_n = 1'b0;
    #1;
    nvec++;
    if ({ks_bit, ks_valid, busy, done} !== 4'b0000) begin
      nerr++;
      $display("FAIL mid_reset got=%b want=0000",
               {ks_bit, ks_valid, busy, done});
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    nvec++;
    if ({ks_valid, busy} !== 2'b00) begin
      nerr++;
      $display("FAIL mid_idle got=%b want=00",
               {ks_valid, busy});
    end
    run_capture(kat_key, kat_frm, 1'b0, -1, -1,
                nv, fv, dc, ec, dn, b, us, tmo, b1);
    nvec++;
    if (tmo !== 1'b0 || nv != 114 ||
        b[119:6] !== kat[119:6]) begin
      nerr++;
      $display("FAIL mid_rerun got=%h n=%0d want=%h",
               b, nv, kat);
    end
  endtask

  task automatic test_zero_key();
    int nv, fv, dc, ec, dn, us;
    logic [119:0] b;
    bit tmo, b1;
    run_capture(64'h0, 22'h0, 1'b0, -1, -1,
                nv, fv, dc, ec, dn, b, us, tmo, b1);
    nvec++;
    if (tmo !== 1'b0 || nv != 114 || dn != 1) begin
      nerr++;
      $display("FAIL zero_count got=%0d/%0d want=114/1",
               nv, dn);
    end
    nvec++;
    if (b !== 120'h0) begin
      nerr++;
      $display("FAIL zero_bits got=%h want=0", b);
    end
    nvec++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      nerr++;
      $display("FAIL zero_after got=%b want=00",
               {busy, done});
    end
  endtask

  initial begin
    nvec    = 0;
    nerr    = 0;
    kat_key = 64'hEFCDAB8967452312;
    kat_frm = 22'h134;
    kat     = 120'h534EAA582FE8151AB6E1855A728C00;
    rst_n   = 1'b0;
    start   = 1'b0;
    ks_en   = 1'b1;
    key     = '0;
    frame   = '0;
    test_reset();
    test_known_answer();
    test_stall();
    test_start_while_busy();
    test_start_on_done();
    test_reset_mid_run();
    test_zero_key();
    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
